// File: rtl/msx_spi_host_pkg.sv
// Shared constants and types for the MSX host SPI command port.
// Opcodes, the idle response byte, status bit positions and the command-state enum.
package msx_spi_host_pkg;

   localparam logic [7:0] CMD_PING     = 8'h00;
   localparam logic [7:0] CMD_RUN      = 8'h02;
   localparam logic [7:0] CMD_KEY      = 8'h03;
   localparam logic [7:0] CMD_DOWNLOAD = 8'h04;
   localparam logic [7:0] CMD_STATUS   = 8'h05;
   localparam logic [7:0] CMD_HALT     = 8'h06;

   localparam logic [7:0] RESP_IDLE = 8'hA5;

   localparam int ST_BUSY = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_FULL = 2;
   localparam int ST_OVF  = 3;

   typedef enum logic [2:0] {
      IDLE,
      ARG1,
      ARG2,
      STREAM,
      IGNORE
   } cmd_state_e;

   function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                              input logic run, input logic busy);
      logic [7:0] s;
      s          = '0;
      s[ST_OVF]  = ovf;
      s[ST_FULL] = full;
      s[ST_RUN]  = run;
      s[ST_BUSY] = busy;
      return s;
   endfunction

endpackage

// File: rtl/msx_spi_wr_fifo.sv
// Synchronous download FIFO between the SPI command decoder and the SDRAM arbiter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module msx_spi_wr_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
   always_comb begin
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; pointer reset alone makes the contents invisible.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/msx_spi_host_if.sv
// SPI-slave (mode 3) command port from the host MCU: key matrix, status, image download, CPU run/halt.
// Downloaded bytes are buffered and drained to the SDRAM arbiter with a req/ack handshake.
module msx_spi_host_if #(
   parameter  int KEY_ROWS    = 16,
   parameter  int BANK_BITS   = 8,
   parameter  int OFFSET_BITS = 14,
   parameter  int FIFO_DEPTH  = 8,
   localparam int ROW_W       = $clog2(KEY_ROWS),
   localparam int ADDR_W      = BANK_BITS + OFFSET_BITS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic              sdram_busy,
   output logic              key_we,
   output logic [ROW_W-1:0]  key_row,
   output logic [7:0]        key_data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              cpu_run,
   output logic              cpu_reset
);

   import msx_spi_host_pkg::*;

   localparam int ENTRY_W = ADDR_W + 8;

   logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
   logic       sclk_prev_q;
   logic       cs_n_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [6:0]             rx_q, rx_d;
   logic [7:0]             tx_q, tx_d;
   cmd_state_e             state_q, state_d;
   logic [7:0]             op_q, op_d;
   logic [7:0]             row_q, row_d;
   logic [BANK_BITS-1:0]   bank_q, bank_d;
   logic [OFFSET_BITS-1:0] offset_q, offset_d;
   logic                   key_we_q, key_we_d;
   logic [ROW_W-1:0]       key_row_q, key_row_d;
   logic [7:0]             key_data_q, key_data_d;
   logic                   cpu_run_q, cpu_run_d;
   logic                   cpu_reset_q, cpu_reset_d;
   logic                   push_q, push_d;
   logic [ENTRY_W-1:0]     push_data_q, push_data_d;
   logic                   ovf_q, ovf_d;

   logic [7:0]         rx_byte;
   logic               status_load;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_full, fifo_empty;

   assign cs_n_s    = cs_sync_q[1];
   assign sclk_s    = sclk_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sclk_rise = !cs_n_s && sclk_s && !sclk_prev_q;
   assign sclk_fall = !cs_n_s && !sclk_s && sclk_prev_q;

   // Synchronisers idle at the mode-3 bus idle levels: CS high, clock high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b11;
         mosi_sync_q <= 2'b00;
         sclk_prev_q <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
         sclk_sync_q <= {sclk_sync_q[0], spi_clk};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
         sclk_prev_q <= sclk_s;
      end
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      state_d     = state_q;
      op_d        = op_q;
      row_d       = row_q;
      bank_d      = bank_q;
      offset_d    = offset_q;
      key_we_d    = 1'b0;
      key_row_d   = key_row_q;
      key_data_d  = key_data_q;
      cpu_run_d   = cpu_run_q;
      cpu_reset_d = 1'b0;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      status_load = 1'b0;
      rx_byte     = {rx_q, mosi_s};

      if (cs_n_s) begin
         bit_cnt_d = '0;
         state_d   = IDLE;
         tx_d      = RESP_IDLE;
      end else if (sclk_rise) begin
         rx_d      = rx_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            tx_d = RESP_IDLE;
            unique case (state_q)
               IDLE: begin
                  op_d    = rx_byte;
                  state_d = IGNORE;
                  case (rx_byte)
                     CMD_RUN:  cpu_run_d = 1'b1;
                     CMD_HALT: begin
                        cpu_run_d   = 1'b0;
                        cpu_reset_d = 1'b1;
                     end
                     CMD_KEY, CMD_DOWNLOAD: state_d = ARG1;
                     CMD_STATUS: begin
                        tx_d        = status_byte(ovf_q, fifo_full, cpu_run_q, sdram_busy);
                        status_load = 1'b1;
                     end
                     default: ;
                  endcase
               end
               ARG1: begin
                  if (op_q == CMD_KEY) begin
                     row_d   = rx_byte;
                     state_d = ARG2;
                  end else begin
                     bank_d   = rx_byte[BANK_BITS-1:0];
                     offset_d = '0;
                     state_d  = STREAM;
                  end
               end
               ARG2: begin
                  if (int'(row_q) < KEY_ROWS) begin
                     key_we_d   = 1'b1;
                     key_row_d  = row_q[ROW_W-1:0];
                     key_data_d = rx_byte;
                  end
                  state_d = IGNORE;
               end
               // Offset advances even when the FIFO drops the byte, keeping host addressing in step.
               STREAM: begin
                  push_d      = 1'b1;
                  push_data_d = {bank_q, offset_q, rx_byte};
                  offset_d    = offset_q + OFFSET_BITS'(1);
               end
               default: ;
            endcase
         end
      end else if (sclk_fall && bit_cnt_q != 3'd0) begin
         tx_d = {tx_q[6:0], 1'b0};
      end

      // A same-cycle pop frees a slot, so only a push into a full FIFO without ack overflows.
      ovf_d = ovf_q;
      if (status_load) ovf_d = 1'b0;
      if (push_q && fifo_full && !mem_ack) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= RESP_IDLE;
         state_q     <= IDLE;
         op_q        <= '0;
         row_q       <= '0;
         bank_q      <= '0;
         offset_q    <= '0;
         key_we_q    <= 1'b0;
         key_row_q   <= '0;
         key_data_q  <= '0;
         cpu_run_q   <= 1'b0;
         cpu_reset_q <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         state_q     <= state_d;
         op_q        <= op_d;
         row_q       <= row_d;
         bank_q      <= bank_d;
         offset_q    <= offset_d;
         key_we_q    <= key_we_d;
         key_row_q   <= key_row_d;
         key_data_q  <= key_data_d;
         cpu_run_q   <= cpu_run_d;
         cpu_reset_q <= cpu_reset_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         ovf_q       <= ovf_d;
      end
   end

   msx_spi_wr_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .wr_en  (push_q),
      .wr_data(push_data_q),
      .rd_en  (mem_ack),
      .rd_data(fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign spi_miso  = cs_n_s ? 1'b1 : tx_q[7];
   assign key_we    = key_we_q;
   assign key_row   = key_row_q;
   assign key_data  = key_data_q;
   assign cpu_run   = cpu_run_q;
   assign cpu_reset = cpu_reset_q;
   assign mem_req   = !fifo_empty;
   assign mem_addr  = fifo_empty ? '0 : fifo_head[ENTRY_W-1:8];
   assign mem_wdata = fifo_empty ? '0 : fifo_head[7:0];

endmodule

// File: tb/tb_msx_spi_host_if.sv
// Bench for msx_spi_host_if: SPI host driver, byte-level command model and per-cycle output checker.
// A second instance with a 3-bit offset exposes offset wrap-around within a short download.
module tb_msx_spi_host_if;

   localparam int  KEY_ROWS    = 16;
   localparam int  BANK_BITS   = 8;
   localparam int  OFFSET_BITS = 14;
   localparam int  FIFO_DEPTH  = 8;
   localparam int  AW          = BANK_BITS + OFFSET_BITS;
   localparam int  W_OFF       = 3;
   localparam int  W_AW        = BANK_BITS + W_OFF;
   localparam int  HALF        = 80;

   typedef struct packed {logic [AW-1:0] addr; logic [7:0] data;}   wr_t;
   typedef struct packed {logic [W_AW-1:0] addr; logic [7:0] data;} wrw_t;
   typedef struct packed {logic [3:0] row; logic [7:0] data;}       key_t;

   logic clk, reset_n, spi_cs_n, spi_clk, spi_mosi, spi_miso, sdram_busy;
   logic key_we, mem_req, mem_ack, cpu_run, cpu_reset;
   logic [3:0]    key_row;
   logic [7:0]    key_data, mem_wdata;
   logic [AW-1:0] mem_addr;

   logic w_miso, w_key_we, w_req, w_run, w_rst, w_ack;
   logic [3:0]      w_key_row;
   logic [7:0]      w_key_data, w_wdata;
   logic [W_AW-1:0] w_addr;

   int checks = 0, errors = 0;
   int rst_pulses = 0, exp_pulses = 0;
   logic ack_en = 1'b0, cpu_reset_prev = 1'b0;

   wr_t  exp_wr[$], wr_log[$], e_wr;
   wrw_t exp_w[$], w_log[$], e_w;
   key_t exp_key[$], key_log[$], e_key;

   logic [7:0] cmd[0:15], rsp[0:15], exp_rsp[0:16];
   logic [7:0] m_op;
   int m_row, m_bank, m_off;
   logic m_run = 1'b0, m_ovf = 1'b0;

   msx_spi_host_if #(.KEY_ROWS(KEY_ROWS), .BANK_BITS(BANK_BITS), .OFFSET_BITS(OFFSET_BITS),
                     .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
      .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .sdram_busy(sdram_busy), .key_we(key_we), .key_row(key_row),
      .key_data(key_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .cpu_run(cpu_run), .cpu_reset(cpu_reset));

   msx_spi_host_if #(.KEY_ROWS(KEY_ROWS), .BANK_BITS(BANK_BITS), .OFFSET_BITS(W_OFF),
                     .FIFO_DEPTH(FIFO_DEPTH)) u_dut_w (
      .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(w_miso), .sdram_busy(sdram_busy), .key_we(w_key_we), .key_row(w_key_row),
      .key_data(w_key_data), .mem_req(w_req), .mem_addr(w_addr), .mem_wdata(w_wdata),
      .mem_ack(w_ack), .cpu_run(w_run), .cpu_reset(w_rst));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial w_ack = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got event 0x%0h, expected none", name, act);
   endtask

   // Slave acknowledges each request two cycles after seeing it.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ack_en && mem_req) begin
            repeat (2) begin @(posedge clk); #1; end
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_req && mem_ack) begin
            wr_log.push_back({mem_addr, mem_wdata});
            if (exp_wr.size() == 0) unexpected("wr_unexpected", {2'b0, mem_addr, mem_wdata});
            else begin
               e_wr = exp_wr.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e_wr.addr));
               check("wr_data", 32'(mem_wdata), 32'(e_wr.data));
            end
         end
         if (w_req && w_ack) begin
            w_log.push_back({w_addr, w_wdata});
            if (exp_w.size() == 0) unexpected("wrap_wr_unexpected", 32'({w_addr, w_wdata}));
            else begin
               e_w = exp_w.pop_front();
               check("wrap_wr_addr", 32'(w_addr), 32'(e_w.addr));
               check("wrap_wr_data", 32'(w_wdata), 32'(e_w.data));
            end
         end
         if (key_we) begin
            key_log.push_back({key_row, key_data});
            if (exp_key.size() == 0) unexpected("key_unexpected", 32'({key_row, key_data}));
            else begin
               e_key = exp_key.pop_front();
               check("key_row", 32'(key_row), 32'(e_key.row));
               check("key_data", 32'(key_data), 32'(e_key.data));
            end
         end
         if (cpu_reset) begin
            rst_pulses++;
            check("cpu_reset_width", 32'(cpu_reset_prev), 32'd0);
         end
         cpu_reset_prev = cpu_reset;
      end
   end

   // Command semantics at byte granularity: what each received byte must cause.
   task automatic model_byte(input int k, input logic [7:0] b);
      int addr;
      exp_rsp[k+1] = 8'hA5;
      if (k == 0) begin
         m_op = b;
         case (b)
            8'h02: m_run = 1'b1;
            8'h06: begin m_run = 1'b0; exp_pulses++; end
            8'h05: begin
               exp_rsp[1] = {4'b0, m_ovf, exp_wr.size() >= FIFO_DEPTH, m_run, sdram_busy};
               m_ovf = 1'b0;
            end
            default: ;
         endcase
      end else if (k == 1) begin
         if (m_op == 8'h03) m_row = int'(b);
         if (m_op == 8'h04) begin m_bank = int'(b); m_off = 0; end
      end else begin
         if (k == 2 && m_op == 8'h03 && m_row < KEY_ROWS) exp_key.push_back({4'(m_row), b});
         if (m_op == 8'h04) begin
            addr = m_bank * (1 << OFFSET_BITS) + m_off;
            if (exp_wr.size() < FIFO_DEPTH) exp_wr.push_back({AW'(addr), b});
            else m_ovf = 1'b1;
            exp_w.push_back({W_AW'(m_bank * (1 << W_OFF) + (m_off % (1 << W_OFF))), b});
            m_off = (m_off + 1) % (1 << OFFSET_BITS);
         end
      end
   endtask

   // Mode 3 byte: data changes on the falling edge, both sides sample on the rising edge.
   task automatic xfer(input logic [7:0] b, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) begin
         spi_clk  = 1'b0;
         spi_mosi = b[i];
         #HALF;
         r[i]    = spi_miso;
         spi_clk = 1'b1;
         if (i != 0) #HALF;
      end
   endtask

   task automatic transact(input int n);
      logic [7:0] r;
      exp_rsp[0] = 8'hA5;
      spi_cs_n = 1'b0;
      #HALF;
      for (int k = 0; k < n; k++) begin
         xfer(cmd[k], r);
         rsp[k] = r;
         model_byte(k, cmd[k]);
         #HALF;
      end
      spi_cs_n = 1'b1;
      #(4*HALF);
      for (int k = 0; k < n; k++) check($sformatf("miso_byte%0d", k), 32'(rsp[k]), 32'(exp_rsp[k]));
      check("cpu_run", 32'(cpu_run), 32'(m_run));
      check("cpu_reset_pulses", rst_pulses, exp_pulses);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && (exp_wr.size() != 0 || exp_w.size() != 0); i++) @(negedge clk);
      check("drain_done", 32'(exp_wr.size() + exp_w.size()), 32'd0);
   endtask

   initial begin
      int kb, base, wbase, pulses;
      logic [7:0] r;
      reset_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0; sdram_busy = 1'b1;
      #30;
      check("rst_miso", 32'(spi_miso), 32'd1);
      check("rst_key_we", 32'(key_we), 32'd0);
      check("rst_key_row", 32'(key_row), 32'd0);
      check("rst_key_data", 32'(key_data), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_cpu_run", 32'(cpu_run), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
      @(negedge clk); reset_n = 1'b1;
      repeat (5) @(negedge clk);

      cmd[0] = 8'h00; transact(1);
      check("ping_lit", 32'(rsp[0]), 32'hA5);
      check("miso_idle", 32'(spi_miso), 32'd1);

      cmd[0] = 8'h05; cmd[1] = 8'h00; transact(2);
      check("status_busy_lit", 32'(rsp[1]), 32'h01);
      sdram_busy = 1'b0;
      cmd[0] = 8'h02; transact(1);
      cmd[0] = 8'h05; cmd[1] = 8'h00; cmd[2] = 8'h00; transact(3);
      check("status_run_lit", 32'(rsp[1]), 32'h02);

      kb = key_log.size();
      cmd[0] = 8'h03; cmd[1] = 8'h05; cmd[2] = 8'h7F; transact(3);
      check("key_count", 32'(key_log.size() - kb), 32'd1);
      check("key_row_lit", 32'(key_log[kb].row), 32'd5);
      check("key_data_lit", 32'(key_log[kb].data), 32'h7F);
      kb = key_log.size();
      cmd[0] = 8'h03; cmd[1] = 8'h20; cmd[2] = 8'h00; transact(3);
      check("key_row_range", 32'(key_log.size() - kb), 32'd0);
      cmd[0] = 8'h03; cmd[1] = 8'h0F; cmd[2] = 8'hAA; cmd[3] = 8'hBB; transact(4);
      check("key_trailing", 32'(key_log.size() - kb), 32'd1);

      cmd[0] = 8'h7E; cmd[1] = 8'h11; cmd[2] = 8'h22; transact(3);

      pulses = rst_pulses;
      cmd[0] = 8'h06; transact(1);
      check("halt_pulse", 32'(rst_pulses - pulses), 32'd1);

      ack_en = 1'b1;
      base = wr_log.size(); wbase = w_log.size();
      cmd[0] = 8'h04; cmd[1] = 8'h08;
      for (int i = 0; i < 10; i++) cmd[2+i] = 8'h10 + 8'(i * 17);
      transact(12);
      wait_drain();
      check("dl_addr0_lit", 32'(wr_log[base].addr), 32'h020000);
      check("dl_data0_lit", 32'(wr_log[base].data), 32'h10);
      check("dl_addr3_lit", 32'(wr_log[base+3].addr), 32'h020003);
      check("dl_data3_lit", 32'(wr_log[base+3].data), 32'h43);
      check("wrap_addr7_lit", 32'(w_log[wbase+7].addr), 32'h047);
      check("wrap_addr8_lit", 32'(w_log[wbase+8].addr), 32'h040);
      check("wrap_data8_lit", 32'(w_log[wbase+8].data), 32'h98);

      ack_en = 1'b0;
      cmd[0] = 8'h04; cmd[1] = 8'h01;
      for (int i = 0; i < FIFO_DEPTH + 2; i++) cmd[2+i] = 8'hC0 + 8'(i);
      transact(FIFO_DEPTH + 4);
      check("ovf_req_held", 32'(mem_req), 32'd1);
      cmd[0] = 8'h05; cmd[1] = 8'h00; transact(2);
      check("status_ovf_lit", 32'(rsp[1]), 32'h0C);
      transact(2);
      check("status_ovf_clr_lit", 32'(rsp[1]), 32'h04);
      base = wr_log.size();
      ack_en = 1'b1;
      wait_drain();
      repeat (20) @(negedge clk);
      check("ovf_writes", 32'(wr_log.size() - base), 32'(FIFO_DEPTH));

      ack_en = 1'b0;
      cmd[0] = 8'h02; transact(1);
      spi_cs_n = 1'b0; #HALF;
      cmd[0] = 8'h04; cmd[1] = 8'h02; cmd[2] = 8'h33; cmd[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
         xfer(cmd[k], r);
         model_byte(k, cmd[k]);
         if (k != 3) #HALF;
      end
      for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
      check("rst_pre_req", 32'(mem_req), 32'd1);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("arst_mem_req", 32'(mem_req), 32'd0);
      check("arst_cpu_run", 32'(cpu_run), 32'd0);
      check("arst_miso", 32'(spi_miso), 32'd1);
      check("arst_mem_addr", 32'(mem_addr), 32'd0);
      exp_wr.delete(); exp_w.delete();
      m_run = 1'b0; m_ovf = 1'b0;
      spi_cs_n = 1'b1; spi_clk = 1'b1;
      base = wr_log.size();
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      ack_en  = 1'b1;
      repeat (200) @(negedge clk);
      check("rst_no_writes", 32'(wr_log.size() - base), 32'd0);
      cmd[0] = 8'h05; cmd[1] = 8'h00; transact(2);
      check("status_after_rst_lit", 32'(rsp[1]), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
